sync_fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of one sync_fifo among NREQ producers. Arbitration is round-robin,
//  and each grant lasts for a burst of up to BURST beats. Each producer has a valid/ready interface.
//  The block drives the FIFO's winc/wdata and watches wfull. Each written word is tagged with the

---
 rtl/sync_fifo_arb_pkg.sv | 22 ++
 rtl/sync_fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/sync_fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_sync_fifo_wr_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_arb_pkg.sv
// Shared types and parameter helpers for the FIFO write-port arbiter
// and its round-robin picker.
package sync_fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int MIN_NREQ  = 2;
  localparam int MIN_BURST = 1;

  // Never returns 0, so a width derived from it is always usable.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int nreq, input int burst);
    return (nreq >= MIN_NREQ) && (burst >= MIN_BURST);
  endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request after `last`, wrapping modulo
// NREQ, so non-power-of-2 requester counts work.
module rr_pick
  import sync_fifo_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = clog2_safe(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic            any,
  output logic [ID_W-1:0] win
);

  logic found;
  int   idx;

  assign any = |req;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        win   = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Shares one sync_fifo write port among NREQ valid/ready producers with
// round-robin burst grants; each written word carries its source ID.
module sync_fifo_wr_arbiter
  import sync_fifo_arb_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  parameter  int BURST = 4,
  localparam int ID_W  = clog2_safe(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_winc,
  output logic [ID_W+WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_wfull,
  output logic                  grant_vld,
  output logic [ID_W-1:0]       grant_id
);

  localparam int CNT_W = clog2_safe(BURST);

  if (!params_ok(NREQ, BURST)) begin : g_param_check
    $error("sync_fifo_wr_arbiter: NREQ must be >= 2 and BURST >= 1");
  end

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   last_owner;
  logic [CNT_W-1:0]  beat_cnt;

  logic              pick_any;
  logic [ID_W-1:0]   pick_win;
  logic              owner_valid;
  logic [WIDTH-1:0]  owner_data;
  logic              last_beat;
  logic              xfer;
  logic              release_grant;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req  (req_valid),
    .last (last_owner),
    .any  (pick_any),
    .win  (pick_win)
  );

  assign owner_valid = req_valid[owner];
  assign owner_data  = req_data[int'(owner)*WIDTH +: WIDTH];
  assign last_beat   = (beat_cnt == CNT_W'(BURST - 1));

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (pick_any)      state_nxt = ARB_GRANT;
      ARB_GRANT: if (release_grant) state_nxt = ARB_IDLE;
      default:                      state_nxt = ARB_IDLE;
    endcase
  end

  // ---- output / transfer logic ----
  // A valid drop while the FIFO is full does not release: the owner is only
  // considered idle once it could actually have been accepted.
  always_comb begin
    req_ready     = '0;
    xfer          = 1'b0;
    release_grant = 1'b0;
    fifo_winc     = 1'b0;
    fifo_wdata    = '0;
    grant_vld     = 1'b0;
    if (state == ARB_GRANT) begin
      grant_vld        = 1'b1;
      req_ready[owner] = !fifo_wfull;
      xfer             = owner_valid && !fifo_wfull;
      release_grant    = (xfer && last_beat) || (!owner_valid && !fifo_wfull);
      fifo_winc        = xfer;
      fifo_wdata       = {owner, owner_data};
    end
  end

  assign grant_id = owner;

  // ---- owner, history and beat counter ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner      <= '0;
      last_owner <= ID_W'(NREQ - 1);
      beat_cnt   <= '0;
    end else begin
      if (state == ARB_IDLE && pick_any) begin
        owner    <= pick_win;
        beat_cnt <= '0;
      end
      if (state == ARB_GRANT) begin
        if (release_grant) begin
          last_owner <= owner;
        end else if (xfer) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Directed bench for sync_fifo_wr_arbiter: table of per-cycle vectors plus a
// round-robin streaming sequence and per-cycle protocol checks.
module tb_sync_fifo_wr_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_winc;
  logic [ID_W+WIDTH-1:0] fifo_wdata;
  logic                  fifo_wfull;
  logic                  grant_vld;
  logic [ID_W-1:0]       grant_id;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_fifo_wr_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .BURST (BURST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_winc  (fifo_winc),
    .fifo_wdata (fifo_wdata),
    .fifo_wfull (fifo_wfull),
    .grant_vld  (grant_vld),
    .grant_id   (grant_id)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic [3:0] valid;
    logic       wfull;
    logic [3:0] ready;
    logic       winc;
    logic [9:0] wdata;
    logic       gvld;
    logic [1:0] gid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic r, input logic [3:0] v, input logic wf,
                     input logic [3:0] er, input logic ew, input logic [9:0] ewd,
                     input logic egv, input logic [1:0] egid);
    vec_t t;
    t.name = n; t.rst_n = r; t.valid = v; t.wfull = wf;
    t.ready = er; t.winc = ew; t.wdata = ewd; t.gvld = egv; t.gid = egid;
    vecs.push_back(t);
  endtask

  task automatic check(input string n, input logic [3:0] er, input logic ew,
                       input logic [9:0] ewd, input logic egv, input logic [1:0] egid);
    tests++;
    if (req_ready !== er || fifo_winc !== ew || fifo_wdata !== ewd ||
        grant_vld !== egv || grant_id !== egid) begin
      fails++;
      $display("FAIL %s: got ready=%b winc=%b wdata=%h gvld=%b gid=%0d, expected ready=%b winc=%b wdata=%h gvld=%b gid=%0d",
               n, req_ready, fifo_winc, fifo_wdata, grant_vld, grant_id,
               er, ew, ewd, egv, egid);
    end
  endtask

  // Protocol properties checked every cycle once out of reset.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1) begin
      tests++;
      if (!$onehot0(req_ready) || (fifo_winc && fifo_wfull) || (fifo_winc && !grant_vld)) begin
        fails++;
        $display("FAIL protocol @%0t: ready=%b winc=%b wfull=%b gvld=%b, required onehot0 ready, no winc on full, winc only with grant",
                 $time, req_ready, fifo_winc, fifo_wfull, grant_vld);
      end
    end
  end

  initial begin
    logic [9:0] wd;
    int id;

    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = 8'hA0 + 8'(i);
    rst_n = 1'b0; req_valid = '0; fifo_wfull = 1'b0;

    // single requester: 4 beats, one bubble, regrant
    add("a_rst",     0, 4'b0000, 0, 4'b0000, 0, 10'h000, 0, 0);
    add("a_idle",    1, 4'b0001, 0, 4'b0000, 0, 10'h000, 0, 0);
    add("a_b1",      1, 4'b0001, 0, 4'b0001, 1, 10'h0A0, 1, 0);
    add("a_b2",      1, 4'b0001, 0, 4'b0001, 1, 10'h0A0, 1, 0);
    add("a_b3",      1, 4'b0001, 0, 4'b0001, 1, 10'h0A0, 1, 0);
    add("a_b4",      1, 4'b0001, 0, 4'b0001, 1, 10'h0A0, 1, 0);
    add("a_bubble",  1, 4'b0001, 0, 4'b0000, 0, 10'h000, 0, 0);
    add("a_regrant", 1, 4'b0001, 0, 4'b0001, 1, 10'h0A0, 1, 0);
    // owner 2 stalled by wfull for 5 cycles, including a valid drop
    add("c_rst",     0, 4'b0000, 0, 4'b0001, 0, 10'h0A0, 1, 0);
    add("c_idle",    1, 4'b0100, 0, 4'b0000, 0, 10'h000, 0, 0);
    add("c_b1",      1, 4'b0100, 0, 4'b0100, 1, 10'h2A2, 1, 2);
    add("c_b2",      1, 4'b0100, 0, 4'b0100, 1, 10'h2A2, 1, 2);
    add("c_full1",   1, 4'b0100, 1, 4'b0000, 0, 10'h2A2, 1, 2);
    add("c_full2",   1, 4'b0100, 1, 4'b0000, 0, 10'h2A2, 1, 2);
    add("c_full3",   1, 4'b0000, 1, 4'b0000, 0, 10'h2A2, 1, 2);
    add("c_full4",   1, 4'b0100, 1, 4'b0000, 0, 10'h2A2, 1, 2);
    add("c_full5",   1, 4'b0100, 1, 4'b0000, 0, 10'h2A2, 1, 2);
    add("c_b3",      1, 4'b0100, 0, 4'b0100, 1, 10'h2A2, 1, 2);
    add("c_b4",      1, 4'b0100, 0, 4'b0100, 1, 10'h2A2, 1, 2);
    add("c_done",    1, 4'b0000, 0, 4'b0000, 0, 10'h000, 0, 2);
    // owner 1 goes idle after 2 beats, only 3 still valid
    add("d_rst",     0, 4'b0000, 0, 4'b0000, 0, 10'h000, 0, 2);
    add("d_idle",    1, 4'b1010, 0, 4'b0000, 0, 10'h000, 0, 0);
    add("d_b1",      1, 4'b1010, 0, 4'b0010, 1, 10'h1A1, 1, 1);
    add("d_b2",      1, 4'b1010, 0, 4'b0010, 1, 10'h1A1, 1, 1);
    add("d_drop",    1, 4'b1000, 0, 4'b0010, 0, 10'h1A1, 1, 1);
    add("d_idle2",   1, 4'b1000, 0, 4'b0000, 0, 10'h000, 0, 1);
    add("d_g3",      1, 4'b1000, 0, 4'b1000, 1, 10'h3A3, 1, 3);
    // reset mid-burst of owner 3, then all valid: 0 wins first
    add("e_rst",     0, 4'b1111, 0, 4'b1000, 1, 10'h3A3, 1, 3);
    add("e_after",   1, 4'b1111, 0, 4'b0000, 0, 10'h000, 0, 0);
    add("e_g0",      1, 4'b1111, 0, 4'b0001, 1, 10'h0A0, 1, 0);

    @(negedge clk);
    @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; req_valid = vecs[i].valid; fifo_wfull = vecs[i].wfull;
      #1;
      check(vecs[i].name, vecs[i].ready, vecs[i].winc, vecs[i].wdata, vecs[i].gvld, vecs[i].gid);
    end

    // all requesters valid: grants 0,1,2,3,0 with 4 beats each and one bubble
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; fifo_wfull = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b1111;
    #1;
    check("rr_idle0", 4'b0000, 0, 10'h000, 0, 0);
    for (int g = 0; g < 5; g++) begin
      id = g % NREQ;
      wd = {2'(id), 8'hA0 + 8'(id)};
      for (int b = 0; b < BURST; b++) begin
        @(negedge clk);
        #1;
        check($sformatf("rr_g%0d_b%0d", g, b), 4'(1 << id), 1, wd, 1, 2'(id));
      end
      @(negedge clk);
      #1;
      check($sformatf("rr_bubble%0d", g), 4'b0000, 0, 10'h000, 0, 2'(id));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
